dfg_func_unit: RTL and testbench

//   Parameterised registered functional unit for data-flow-graph datapaths (e.g. the ARF filter).
//   One instance per DFG node: OP selects exact adder (add_0), approximate adder (add_1)
//   or exact multiplier (mul_0). Fully pipelined, one operation accepted per clock.

---
 rtl/dfg_func_unit.sv | 123 ++++++++++++
 tb/tb_dfg_func_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dfg_func_unit.sv
// rtl/dfg_func_unit.sv - registered DFG functional unit: exact add, lower-part-OR add, or pipelined multiply
module dfg_func_unit #(
  parameter int WIDTH       = 16,
  parameter int OP          = 0,
  parameter int APPROX_BITS = 4,
  parameter int MUL_LAT     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             in_valid,
  output logic             out_valid
);

  // Final-stage input: whichever operator is selected presents its result here,
  // together with the valid bit that travelled alongside it.
  logic [WIDTH-1:0] w_fin_data;
  logic             w_fin_valid;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  // Reject parameter combinations the datapath cannot honour.
  if (WIDTH < 2) begin : g_bad_width
    $error("dfg_func_unit: WIDTH must be >= 2");
  end
  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("dfg_func_unit: OP must be 0, 1 or 2");
  end
  if (APPROX_BITS < 0 || APPROX_BITS >= WIDTH) begin : g_bad_approx
    $error("dfg_func_unit: APPROX_BITS must be in 0..WIDTH-1");
  end
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("dfg_func_unit: MUL_LAT must be >= 1");
  end

  if (OP == 0) begin : g_add0
    // Exact adder; carry-out falls off the top.
    assign w_fin_data  = in_0 + in_1;
    assign w_fin_valid = in_valid;
  end else if (OP == 1) begin : g_add1
    if (APPROX_BITS == 0) begin : g_exact
      // No approximated bits: degenerates to the exact adder.
      assign w_fin_data  = in_0 + in_1;
      assign w_fin_valid = in_valid;
    end else begin : g_lor
      localparam int K  = APPROX_BITS;
      localparam int HW = WIDTH - APPROX_BITS;
      logic [K-1:0]  w_low;
      logic          w_carry;
      logic [HW-1:0] w_high;

      // Lower part is a plain OR; the top approximated bit pair predicts the carry
      // into the exact upper adder.
      always_comb begin
        w_low   = in_0[K-1:0] | in_1[K-1:0];
        w_carry = in_0[K-1] & in_1[K-1];
        w_high  = in_0[WIDTH-1:K] + in_1[WIDTH-1:K] + HW'(w_carry);
      end

      assign w_fin_data  = {w_high, w_low};
      assign w_fin_valid = in_valid;
    end
  end else begin : g_mul
    // The low WIDTH bits of the full product depend only on the low WIDTH bits of
    // the operands, so a WIDTH-wide multiply is bit-exact after truncation.
    logic [WIDTH-1:0] w_prod;
    assign w_prod = in_0 * in_1;

    if (MUL_LAT == 1) begin : g_lat1
      assign w_fin_data  = w_prod;
      assign w_fin_valid = in_valid;
    end else begin : g_latn
      localparam int NSTG = MUL_LAT - 1;
      logic [WIDTH-1:0] r_stg_data [0:NSTG-1];
      logic [NSTG-1:0]  r_stg_valid;

      // Delay line ahead of the output register; data only moves alongside a set
      // valid bit, and reset flushes every in-flight result.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < NSTG; i++) begin
            r_stg_data[i] <= '0;
          end
          r_stg_valid <= '0;
        end else begin
          r_stg_valid[0] <= in_valid;
          if (in_valid) begin
            r_stg_data[0] <= w_prod;
          end
          for (int i = 1; i < NSTG; i++) begin
            r_stg_valid[i] <= r_stg_valid[i-1];
            if (r_stg_valid[i-1]) begin
              r_stg_data[i] <= r_stg_data[i-1];
            end
          end
        end
      end

      assign w_fin_data  = r_stg_data[NSTG-1];
      assign w_fin_valid = r_stg_valid[NSTG-1];
    end
  end

  // Output register: loads only when a result completes, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_fin_valid;
      if (w_fin_valid) begin
        r_out <= w_fin_data;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dfg_func_unit.sv
// tb/tb_dfg_func_unit.sv - directed and randomized self-check of all dfg_func_unit operators
module tb_dfg_func_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_0;
  logic [15:0] in_1;
  logic        in_valid;

  logic [15:0] a0_out, a1_out, ax_out, m_out;
  logic        a0_v, a1_v, ax_v, m_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dfg_func_unit #(.WIDTH(16), .OP(0), .APPROX_BITS(4), .MUL_LAT(2)) u_add0 (
    .clk(clk), .rst_n(rst_n), .out(a0_out), .in_0(in_0), .in_1(in_1),
    .in_valid(in_valid), .out_valid(a0_v));

  dfg_func_unit #(.WIDTH(16), .OP(1), .APPROX_BITS(4), .MUL_LAT(2)) u_add1 (
    .clk(clk), .rst_n(rst_n), .out(a1_out), .in_0(in_0), .in_1(in_1),
    .in_valid(in_valid), .out_valid(a1_v));

  dfg_func_unit #(.WIDTH(16), .OP(1), .APPROX_BITS(0), .MUL_LAT(2)) u_add1x (
    .clk(clk), .rst_n(rst_n), .out(ax_out), .in_0(in_0), .in_1(in_1),
    .in_valid(in_valid), .out_valid(ax_v));

  dfg_func_unit #(.WIDTH(16), .OP(2), .APPROX_BITS(4), .MUL_LAT(2)) u_mul (
    .clk(clk), .rst_n(rst_n), .out(m_out), .in_0(in_0), .in_1(in_1),
    .in_valid(in_valid), .out_valid(m_v));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  function automatic logic [15:0] lor_add(input logic [15:0] a, input logic [15:0] b, input int k);
    logic [15:0] mask;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    if (k == 0) return a + b;
    mask = (16'h0001 << k) - 16'h0001;
    lo   = (a | b) & mask;
    c    = a[k-1] & b[k-1];
    hi   = ((a >> k) + (b >> k) + {15'b0, c}) << k;
    return hi | lo;
  endfunction

  function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = {16'b0, a} * {16'b0, b};
    return full[15:0];
  endfunction

  logic [15:0] e_a0, e_a1, e_ax, e_m;
  logic        p_valid;
  logic [15:0] p0, p1;
  int          n_acc, n_mul_out;

  initial begin
    rst_n = 1'b0; in_0 = '0; in_1 = '0; in_valid = 1'b0;
    tick(); tick();
    check("reset add0 out", a0_out, 16'h0);  check("reset add0 valid", {15'b0, a0_v}, 16'h0);
    check("reset add1 out", a1_out, 16'h0);  check("reset add1 valid", {15'b0, a1_v}, 16'h0);
    check("reset add1x out", ax_out, 16'h0); check("reset add1x valid", {15'b0, ax_v}, 16'h0);
    check("reset mul out", m_out, 16'h0);    check("reset mul valid", {15'b0, m_v}, 16'h0);
    rst_n = 1'b1;
    tick();

    // exact add
    in_0 = 16'h1234; in_1 = 16'h0FFF; in_valid = 1'b1;
    tick();
    check("add0 basic out", a0_out, 16'h2233);
    check("add0 basic valid", {15'b0, a0_v}, 16'h1);
    check("add1 k4 basic out", a1_out, 16'h222F);
    check("add1 k0 basic out", ax_out, 16'h2233);

    // wrap, then idle hold
    in_0 = 16'hFFFF; in_1 = 16'h0002;
    tick();
    check("add0 wrap out", a0_out, 16'h0001);
    in_valid = 1'b0;
    tick();
    check("add0 idle valid", {15'b0, a0_v}, 16'h0);
    check("add0 idle hold", a0_out, 16'h0001);

    // approximate adder
    in_0 = 16'h000F; in_1 = 16'h0001; in_valid = 1'b1;
    tick();
    check("add1 k4 no-carry out", a1_out, 16'h000F);
    check("add1 k4 valid", {15'b0, a1_v}, 16'h1);
    check("add1 k0 exact out", ax_out, 16'h0010);
    in_0 = 16'h0018; in_1 = 16'h0008;
    tick();
    check("add1 k4 carry out", a1_out, 16'h0028);
    in_valid = 1'b0;
    tick(); tick();

    // multiplier, back to back
    in_0 = 16'h0012; in_1 = 16'h0034; in_valid = 1'b1;
    tick();
    check("mul first-edge valid", {15'b0, m_v}, 16'h0);
    in_0 = 16'h0100; in_1 = 16'h0100;
    tick();
    check("mul first out", m_out, 16'h03A8);
    check("mul first valid", {15'b0, m_v}, 16'h1);
    in_valid = 1'b0;
    tick();
    check("mul second out", m_out, 16'h0000);
    check("mul second valid", {15'b0, m_v}, 16'h1);
    tick();
    check("mul drain valid", {15'b0, m_v}, 16'h0);
    check("mul drain hold", m_out, 16'h0000);

    // reset discards an in-flight multiply
    in_0 = 16'h0003; in_1 = 16'h0005; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("mul reset out", m_out, 16'h0000);
    check("mul reset valid", {15'b0, m_v}, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mul post-reset valid", {15'b0, m_v}, 16'h0);
      check("mul post-reset out", m_out, 16'h0000);
    end

    // randomized run against the reference model
    e_a0 = '0; e_a1 = '0; e_ax = '0; e_m = '0;
    p_valid = 1'b0; p0 = '0; p1 = '0;
    n_acc = 0; n_mul_out = 0;
    for (int i = 0; i < 3000; i++) begin
      in_0 = 16'($urandom);
      in_1 = 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      tick();
      if (in_valid) begin
        e_a0 = in_0 + in_1;
        e_a1 = lor_add(in_0, in_1, 4);
        e_ax = lor_add(in_0, in_1, 0);
        n_acc++;
      end
      if (p_valid) e_m = mul16(p0, p1);
      if (m_v) n_mul_out++;
      check("rand add0 valid", {15'b0, a0_v}, {15'b0, in_valid});
      check("rand add0 out", a0_out, e_a0);
      check("rand add1 valid", {15'b0, a1_v}, {15'b0, in_valid});
      check("rand add1 out", a1_out, e_a1);
      check("rand add1x valid", {15'b0, ax_v}, {15'b0, in_valid});
      check("rand add1x out", ax_out, e_ax);
      check("rand mul valid", {15'b0, m_v}, {15'b0, p_valid});
      check("rand mul out", m_out, e_m);
      p_valid = in_valid; p0 = in_0; p1 = in_1;
    end
    in_valid = 1'b0;
    tick();
    if (m_v) n_mul_out++;
    check("rand mul result count", 16'(n_mul_out), 16'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
